ai_train_ctrl: RTL and testbench

Training scheduler for the perceptron branch predictor. It accepts resolved-branch events from the execute stage over a valid/ready handshake and filters them with the perceptron training rule. Surviving events are buffered in a small FIFO and issued to the predictor's training port as single-cycle `train_en` pulses, with an optional minimum gap between pulses. It also keeps saturating statistics counters for performance debug.

---
 rtl/ai_train_ctrl.sv | 160 ++++++++++++++++
 tb/tb_ai_train_ctrl.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ai_train_ctrl.sv
// Perceptron training scheduler: filters resolved branches, queues survivors and issues paced
// train_en pulses. Define AI_TRAIN_FILTER_EN to enable the confidence-threshold filter.
module ai_train_ctrl #(
    parameter int DEPTH  = 4,
    parameter int THRESH = 8,
    parameter int GAP    = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               res_valid,
    output logic               res_ready,
    input  logic [7:0]         res_features,
    input  logic               res_taken,
    input  logic               res_pred,
    input  logic signed [10:0] res_conf,
    input  logic               flush,
    input  logic               hold,
    output logic               train_en,
    output logic [7:0]         train_features,
    output logic               train_taken,
    output logic               busy,
    output logic [15:0]        stat_total,
    output logic [15:0]        stat_mispred,
    output logic [15:0]        stat_trained
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

    state_t        state;
    logic [8:0]    mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic [2:0]    gap_cnt;
    logic [8:0]    head;
    logic          accept;
    logic          keep;
    logic          push;
    logic          can_issue;
    logic          pop;

`ifdef AI_TRAIN_FILTER_EN
    logic [10:0] conf_mag;
    logic [11:0] conf_abs;

    // Magnitude is widened after negation so that -1024 reads as 1024, not as a negative value.
    assign conf_mag = res_conf[10] ? (~res_conf + 11'd1) : res_conf;
    assign conf_abs = {1'b0, conf_mag};
    assign keep     = (res_pred != res_taken) || (conf_abs <= 12'(THRESH));
`else
    logic unused_conf;

    assign unused_conf = ^{res_conf, THRESH[0]};
    assign keep        = 1'b1;
`endif

    assign res_ready = !rst && !flush && (count < CW'(DEPTH));
    assign accept    = res_valid && res_ready;
    assign push      = accept && keep;
    assign can_issue = (count != '0) && !hold && !flush;
    assign head      = mem[rd_ptr];
    assign busy      = (count != '0) || (state != IDLE);

    // The last WAIT cycle doubles as the IDLE issue decision, so pulses can repeat every GAP+1 cycles.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        pop = 1'b0;
        unique case (state)
            IDLE:    pop = can_issue;
            ISSUE:   pop = (GAP == 0) && can_issue;
            WAIT:    pop = (gap_cnt == 3'd1) && can_issue;
            default: pop = 1'b0;
        endcase
    end

    // NOTE: the storage array has no reset; count and the pointers alone define which entries are live.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= {res_features, res_taken};
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            wr_ptr         <= '0;
            rd_ptr         <= '0;
            count          <= '0;
            gap_cnt        <= '0;
            train_en       <= 1'b0;
            train_features <= '0;
            train_taken    <= 1'b0;
        end else if (flush) begin
            state    <= IDLE;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            gap_cnt  <= '0;
            train_en <= 1'b0;
        end else begin
            train_en <= pop;
            count    <= count + CW'(push) - CW'(pop);
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr         <= rd_ptr + PW'(1);
                train_features <= head[8:1];
                train_taken    <= head[0];
            end
            unique case (state)
                IDLE: begin
                    if (pop) state <= ISSUE;
                end
                ISSUE: begin
                    if (pop) begin
                        state <= ISSUE;
                    end else if (GAP > 0) begin
                        gap_cnt <= 3'(GAP);
                        state   <= WAIT;
                    end else begin
                        state <= IDLE;
                    end
                end
                WAIT: begin
                    if (gap_cnt == 3'd1) begin
                        gap_cnt <= '0;
                        state   <= pop ? ISSUE : IDLE;
                    end else begin
                        gap_cnt <= gap_cnt - 3'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Statistics survive flush and saturate rather than wrap.
    always_ff @(posedge clk) begin
        if (rst) begin
            stat_total   <= '0;
            stat_mispred <= '0;
            stat_trained <= '0;
        end else begin
            if (accept && stat_total != 16'hFFFF) begin
                stat_total <= stat_total + 16'd1;
            end
            if (accept && (res_pred != res_taken) && stat_mispred != 16'hFFFF) begin
                stat_mispred <= stat_mispred + 16'd1;
            end
            if (pop && stat_trained != 16'hFFFF) begin
                stat_trained <= stat_trained + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_ai_train_ctrl.sv
// Self-checking bench for ai_train_ctrl: directed scenarios plus randomized traffic checked
// against a queue-and-timestamp reference model.
module tb_ai_train_ctrl;
    localparam int DEPTH  = 4;
    localparam int THRESH = 8;
    localparam int GAP    = 1;

    logic               clk = 1'b0;
    logic               rst;
    logic               res_valid;
    logic               res_ready;
    logic [7:0]         res_features;
    logic               res_taken;
    logic               res_pred;
    logic signed [10:0] res_conf;
    logic               flush;
    logic               hold;
    logic               train_en;
    logic [7:0]         train_features;
    logic               train_taken;
    logic               busy;
    logic [15:0]        stat_total;
    logic [15:0]        stat_mispred;
    logic [15:0]        stat_trained;

    ai_train_ctrl #(.DEPTH(DEPTH), .THRESH(THRESH), .GAP(GAP)) dut (
        .clk(clk), .rst(rst),
        .res_valid(res_valid), .res_ready(res_ready),
        .res_features(res_features), .res_taken(res_taken),
        .res_pred(res_pred), .res_conf(res_conf),
        .flush(flush), .hold(hold),
        .train_en(train_en), .train_features(train_features), .train_taken(train_taken),
        .busy(busy),
        .stat_total(stat_total), .stat_mispred(stat_mispred), .stat_trained(stat_trained)
    );

    always #5 clk = ~clk;

    // Reference model: a queue of pending entries plus the edge index of the last issue.
    logic [8:0]  q[$];
    logic        m_en;
    logic [7:0]  m_feat;
    logic        m_taken;
    logic [15:0] m_total;
    logic [15:0] m_mis;
    logic [15:0] m_trained;
    int          last_pop;
    int          edge_n;
    int          n_cmp;
    int          n_mis;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    // Called at a negedge with inputs already driven; returns at the next negedge.
    task automatic tick();
        logic       rdy;
        logic       acc;
        logic       keep;
        logic       do_pop;
        logic [8:0] ent;
        int         mag;
        #1;
        rdy = !rst && !flush && (q.size() < DEPTH);
        check("res_ready", 32'(res_ready), 32'(rdy));
        mag = int'(res_conf);
        if (mag < 0) mag = -mag;
`ifdef AI_TRAIN_FILTER_EN
        keep = (res_pred != res_taken) || (mag <= THRESH);
`else
        keep = 1'b1;
`endif
        acc    = res_valid && rdy;
        do_pop = !rst && !flush && (q.size() != 0) && !hold && ((edge_n + 1 - last_pop) > GAP);
        @(posedge clk);
        edge_n++;
        if (rst) begin
            q.delete();
            m_en = 1'b0; m_feat = '0; m_taken = 1'b0;
            m_total = '0; m_mis = '0; m_trained = '0;
            last_pop = -100;
        end else if (flush) begin
            q.delete();
            m_en = 1'b0;
            last_pop = -100;
        end else begin
            m_en = do_pop;
            if (do_pop) begin
                ent       = q.pop_front();
                m_feat    = ent[8:1];
                m_taken   = ent[0];
                last_pop  = edge_n;
                m_trained = sat_inc(m_trained);
            end
            if (acc) begin
                m_total = sat_inc(m_total);
                if (res_pred != res_taken) m_mis = sat_inc(m_mis);
                if (keep) q.push_back({res_features, res_taken});
            end
        end
        @(negedge clk);
        check("train_en", 32'(train_en), 32'(m_en));
        check("train_features", 32'(train_features), 32'(m_feat));
        check("train_taken", 32'(train_taken), 32'(m_taken));
        check("busy", 32'(busy), 32'((q.size() != 0) || ((edge_n - last_pop) <= GAP)));
        check("stat_total", 32'(stat_total), 32'(m_total));
        check("stat_mispred", 32'(stat_mispred), 32'(m_mis));
        check("stat_trained", 32'(stat_trained), 32'(m_trained));
    endtask

    task automatic drive(input logic v, input logic [7:0] f, input logic t, input logic p, input int c);
        res_valid    = v;
        res_features = f;
        res_taken    = t;
        res_pred     = p;
        res_conf     = 11'(c);
    endtask

    task automatic idle(input int n);
        drive(1'b0, 8'h00, 1'b0, 1'b0, 0);
        repeat (n) tick();
    endtask

    task automatic send(input logic [7:0] f, input logic t, input logic p, input int c);
        drive(1'b1, f, t, p, c);
        tick();
        drive(1'b0, 8'h00, 1'b0, 1'b0, 0);
    endtask

    task automatic do_reset();
        rst = 1'b1; flush = 1'b0; hold = 1'b0;
        drive(1'b0, 8'h00, 1'b0, 1'b0, 0);
        repeat (3) begin
            tick();
            check("rst_train_en", 32'(train_en), 32'd0);
            check("rst_busy", 32'(busy), 32'd0);
            check("rst_stat_total", 32'(stat_total), 32'd0);
        end
        rst = 1'b0;
        #1;
        check("post_rst_ready", 32'(res_ready), 32'd1);
    endtask

    int pe[8];
    int pf[8];
    int np;
    int rel;
    int c;

    initial begin
        n_cmp = 0; n_mis = 0; edge_n = 0; last_pop = -100;
        m_en = 1'b0; m_feat = '0; m_taken = 1'b0;
        m_total = '0; m_mis = '0; m_trained = '0;

        // Reset
        do_reset();
        check("rst_ready_low_probe", 32'(busy), 32'd0);

        // Single event: pulse exactly one cycle after the accept edge
        send(8'hA5, 1'b1, 1'b0, -3);
        tick();
        check("single_en", 32'(train_en), 32'd1);
        check("single_feat", 32'(train_features), 32'hA5);
        check("single_taken", 32'(train_taken), 32'd1);
        tick();
        check("single_en_drop", 32'(train_en), 32'd0);
        idle(3);
        check("single_total", 32'(stat_total), 32'd1);
        check("single_mispred", 32'(stat_mispred), 32'd1);
        check("single_trained", 32'(stat_trained), 32'd1);

        // Filter: confident correct prediction, then one at the threshold
        do_reset();
        send(8'h3C, 1'b1, 1'b1, 20);
        idle(4);
        check("filt_total", 32'(stat_total), 32'd1);
`ifdef AI_TRAIN_FILTER_EN
        check("filt_trained_hi_conf", 32'(stat_trained), 32'd0);
`else
        check("filt_trained_hi_conf", 32'(stat_trained), 32'd1);
`endif
        send(8'h3D, 1'b1, 1'b1, -8);
        idle(4);
`ifdef AI_TRAIN_FILTER_EN
        check("filt_trained_at_thr", 32'(stat_trained), 32'd1);
`else
        check("filt_trained_at_thr", 32'(stat_trained), 32'd2);
`endif
        check("filt_feat_at_thr", 32'(train_features), 32'h3D);

        // Full: five back-to-back events under hold, fifth refused
        do_reset();
        hold = 1'b1;
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 8'(8'h10 + i), 1'b1, 1'b0, 100);
            #1;
            check("full_ready", 32'(res_ready), (i < 4) ? 32'd1 : 32'd0);
            tick();
        end
        drive(1'b0, 8'h00, 1'b0, 1'b0, 0);
        check("full_total", 32'(stat_total), 32'd4);
        hold = 1'b0;
        rel  = edge_n + 1;
        np   = 0;
        for (int i = 0; i < 8; i++) begin
            pe[i] = -1;
            pf[i] = -1;
        end
        for (int i = 0; i < 10; i++) begin
            tick();
            if (train_en === 1'b1 && np < 8) begin
                pe[np] = edge_n;
                pf[np] = int'(train_features);
                np++;
            end
        end
        check("full_npulses", 32'(np), 32'd4);
        for (int i = 0; i < 4; i++) begin
            check("full_pulse_edge", 32'(pe[i] - rel), 32'(2 * i));
            check("full_pulse_feat", 32'(pf[i]), 32'(8'h10 + i));
        end

        // Flush: three queued under hold, flush with a concurrent valid
        do_reset();
        hold = 1'b1;
        for (int i = 0; i < 3; i++) send(8'(8'h20 + i), 1'b0, 1'b1, 5);
        drive(1'b1, 8'h2F, 1'b0, 1'b1, 5);
        flush = 1'b1;
        #1;
        check("flush_ready", 32'(res_ready), 32'd0);
        tick();
        flush = 1'b0;
        hold  = 1'b0;
        drive(1'b0, 8'h00, 1'b0, 1'b0, 0);
        check("flush_busy", 32'(busy), 32'd0);
        idle(6);
        check("flush_trained", 32'(stat_trained), 32'd0);
        check("flush_total", 32'(stat_total), 32'd3);
        check("flush_mispred", 32'(stat_mispred), 32'd3);

        // Saturation of stat_mispred
        do_reset();
        force dut.stat_mispred = 16'hFFFD;
        #1;
        release dut.stat_mispred;
        m_mis = 16'hFFFD;
        send(8'h41, 1'b1, 1'b0, 0);
        check("sat_fffe", 32'(stat_mispred), 32'hFFFE);
        send(8'h42, 1'b0, 1'b1, 0);
        check("sat_ffff", 32'(stat_mispred), 32'hFFFF);
        send(8'h43, 1'b1, 1'b0, 0);
        check("sat_hold", 32'(stat_mispred), 32'hFFFF);
        idle(8);

        // Randomized traffic against the model
        do_reset();
        for (int i = 0; i < 600; i++) begin
            case ($urandom_range(0, 5))
                0:       c = -1024;
                1:       c = 8;
                2:       c = -8;
                3:       c = 9;
                4:       c = -9;
                default: c = int'($urandom_range(0, 2047)) - 1024;
            endcase
            res_taken = 1'($urandom);
            drive(($urandom_range(0, 9) < 7), 8'($urandom), res_taken,
                  ($urandom_range(0, 9) < 6) ? res_taken : ~res_taken, c);
            hold  = ($urandom_range(0, 9) < 2);
            flush = ($urandom_range(0, 99) < 3);
            tick();
        end
        flush = 1'b0;
        hold  = 1'b0;
        idle(20);
        check("drain_busy", 32'(busy), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
